mac_accumulator: RTL and testbench
==================================

MAC_ACCUMULATOR -- requirements
Module: mac_accumulator

Interface
REQ-001 Parameter ACC_W, default 40, accumulator and result width in bits; legal range 33..64.
REQ-002 Parameter CNT_W, default 16, beat-counter width in bits.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 prod_in  input  32  signed two's-complement product, taken from the 16x16 multiplier's result_out.
REQ-007 in_valid  input  1  prod_in and in_last are valid this cycle.
REQ-008 in_last  input  1  marks the final product of a group; meaningful only with in_valid.
REQ-009 in_ready  output  1  block accepts a beat this cycle.
REQ-010 out_valid  output  1  acc_out, cnt_out and ovf_out hold a completed group result.
REQ-011 out_ready  input  1  consumer accepts the result.
REQ-012 acc_out  output  ACC_W  signed sum of the group's products.
REQ-013 cnt_out  output  CNT_W  number of beats in the group.
REQ-014 ovf_out  output  1  signed overflow occurred at least once in the group.

Function
REQ-015 The FSM SHALL have exactly two states, ACCUM and HOLD, and reset SHALL place it in ACCUM.
REQ-016 in_ready SHALL be 1 in ACCUM and 0 in HOLD, decoded from state only, with no combinational path from in_valid or out_ready.
REQ-017 A beat SHALL be accepted when in_valid and in_ready are both 1 at a rising edge.
REQ-018 The block SHALL sign-extend prod_in to ACC_W and add it to the running accumulator acc, wrapping modulo 2^ACC_W.
REQ-019 Each accepted beat SHALL increment the running count, saturating at 2^CNT_W-1.
REQ-020 Signed overflow SHALL be detected when both addends have the same sign and the sum's sign differs; the running ovf flag is sticky for the group.
REQ-021 An accepted beat with in_last=0 SHALL update acc, count and ovf and leave the state in ACCUM.
REQ-022 An accepted beat with in_last=1 SHALL, on that edge, load acc_out, cnt_out and ovf_out with the values including the beat, clear acc, count and ovf to 0, set out_valid=1 and move to HOLD.
REQ-023 Latency SHALL be one cycle: a last beat accepted at edge n gives out_valid=1 in the cycle after edge n.
REQ-024 In HOLD, out_valid, acc_out, cnt_out and ovf_out SHALL remain stable until out_ready=1 at a rising edge.
REQ-025 When out_valid and out_ready are both 1 at an edge, out_valid SHALL clear and the state SHALL return to ACCUM; no beat is accepted on that edge.
REQ-026 Any in_valid asserted during HOLD SHALL be ignored; the producer holds its data until in_ready=1.
REQ-027 Sustained throughput SHALL be one beat per cycle within a group, with a minimum of one non-accepting HOLD cycle between groups.
REQ-028 A single-beat group (in_last on the first beat) SHALL give acc_out equal to sext(prod_in) and cnt_out=1.
REQ-029 acc_out, cnt_out and ovf_out SHALL hold their last delivered values while out_valid=0.

Reset
REQ-030 On rst=1 at an edge, the block SHALL set state=ACCUM, acc=0, count=0, ovf=0, out_valid=0, acc_out=0, cnt_out=0 and ovf_out=0.
REQ-031 rst SHALL take priority over every handshake in the same cycle.
REQ-032 Reset during a partial group SHALL discard the group without producing any output.
REQ-033 Reset in HOLD SHALL drop the pending result.
REQ-034 in_ready SHALL be 1 in the first cycle after reset is released.

Verification
REQ-035 Scenario: beats 100, -30, 5 (last) on consecutive cycles, out_ready=1 -> one cycle after the last beat, out_valid=1, acc_out=75, cnt_out=3, ovf_out=0; out_valid=0 on the following cycle.
REQ-036 Scenario: single beat 0x80000000 with in_last -> acc_out=-2147483648 sign-extended to ACC_W, cnt_out=1.
REQ-037 Scenario: ACC_W=33, three beats of 0x7FFFFFFF, last on the third -> acc_out=-2147483651 (wrapped), ovf_out=1; the next group of beats 1, 1 (last) -> acc_out=2, ovf_out=0.
REQ-038 Scenario: out_ready held 0 for 5 cycles after the result, with in_valid=1 and value 7 presented -> in_ready=0 and outputs stable for all 5 cycles; after release, the value 7 is accepted into the new group.
REQ-039 Scenario: rst pulsed after 2 of 4 beats, then beats 9, 1 (last) -> acc_out=10, cnt_out=2, and no output for the aborted group.
REQ-040 Scenario: back-to-back groups at maximum rate with random out_ready stalls -> every acc_out matches a reference model sum and no beat is lost or duplicated.

Source files
------------

// File: rtl/mac_accumulator.sv
// mac_accumulator
//
// Sums a stream of signed 32-bit products into groups. Each group ends
// with a beat marked in_last. The finished group is presented as one
// result, using a valid/ready handshake. While a result waits for the
// consumer, the block refuses new beats. This means a single result
// register is enough.
//
// Parameters
//   ACC_W      accumulator and result width (33..64)
//   CNT_W      beat-counter width
//
// Ports
//   clk        rising-edge clock for all state
//   rst        synchronous, active-high reset
//   prod_in    signed product from the 16x16 multiplier
//   in_valid   prod_in / in_last are valid this cycle
//   in_last    final product of the current group
//   in_ready   block accepts a beat this cycle (state decode only)
//   out_valid  acc_out / cnt_out / ovf_out hold a completed group
//   out_ready  consumer takes the result
//   acc_out    signed group sum, wrapped modulo 2^ACC_W
//   cnt_out    beats in the group, saturating
//   ovf_out    signed overflow happened somewhere in the group

module mac_accumulator #(
    parameter int ACC_W = 40,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      prod_in,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic [CNT_W-1:0] cnt_out,
    output logic             ovf_out
);

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic [ACC_W-1:0] acc_out_q, acc_out_d;
    logic [CNT_W-1:0] cnt_out_q, cnt_out_d;
    logic             ovf_out_q, ovf_out_d;

    logic [ACC_W-1:0] prod_ext;
    logic [ACC_W-1:0] sum;
    logic [CNT_W-1:0] cnt_inc;
    logic             beat_ovf;

    // Both handshake outputs are pure state decodes. This keeps
    // combinational paths away from in_valid and out_ready.
    assign in_ready  = (state_q == ACCUM);
    assign out_valid = (state_q == HOLD);

    assign acc_out = acc_out_q;
    assign cnt_out = cnt_out_q;
    assign ovf_out = ovf_out_q;

    // Datapath for one beat. Overflow means the two addends share a sign
    // and the wrapped sum does not. The count sticks at all-ones instead
    // of rolling over.
    always_comb begin
        prod_ext = {{(ACC_W-32){prod_in[31]}}, prod_in};
        sum      = acc_q + prod_ext;
        beat_ovf = (acc_q[ACC_W-1] == prod_ext[ACC_W-1]) &&
                   (sum[ACC_W-1] != acc_q[ACC_W-1]);
        cnt_inc  = (&cnt_q) ? cnt_q : (cnt_q + CNT_ONE);
    end

    // Next-state logic. A last beat goes straight into the result
    // registers and clears the running totals on the same edge. The next
    // group can then begin as soon as the result is taken.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        acc_out_d = acc_out_q;
        cnt_out_d = cnt_out_q;
        ovf_out_d = ovf_out_q;
        case (state_q)
            ACCUM: begin
                if (in_valid) begin
                    if (in_last) begin
                        acc_out_d = sum;
                        cnt_out_d = cnt_inc;
                        ovf_out_d = ovf_q | beat_ovf;
                        acc_d     = '0;
                        cnt_d     = '0;
                        ovf_d     = 1'b0;
                        state_d   = HOLD;
                    end else begin
                        acc_d = sum;
                        cnt_d = cnt_inc;
                        ovf_d = ovf_q | beat_ovf;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = ACCUM;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    // State registers. Reset takes priority over any handshake in the
    // same cycle. It discards a partial group and any pending result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ACCUM;
            acc_q     <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            acc_out_q <= '0;
            cnt_out_q <= '0;
            ovf_out_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
            acc_out_q <= acc_out_d;
            cnt_out_q <= cnt_out_d;
            ovf_out_q <= ovf_out_d;
        end
    end

endmodule

// File: tb/tb_mac_accumulator.sv
// tb_mac_accumulator
//
// Drives two accumulators (ACC_W=40 and ACC_W=33) from the same beat
// stream. The driver keeps a reference model and queues one expected
// result per group. A monitor compares that result against both
// instances on every cycle a result is presented.

module tb_mac_accumulator;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] prodIn = '0;
    logic        inValid = 1'b0;
    logic        inLast = 1'b0;
    logic        outReady = 1'b1;

    logic        inReady, outValid, ovfOut;
    logic [39:0] accOut;
    logic [15:0] cntOut;
    logic        inReady33, outValid33, ovfOut33;
    logic [32:0] accOut33;
    logic [15:0] cntOut33;

    typedef struct {
        logic [39:0] acc40;
        logic        ovf40;
        logic [32:0] acc33;
        logic        ovf33;
        logic [15:0] cnt;
    } result_t;

    result_t     expQ[$];
    longint      model40, model33;
    logic        mOvf40, mOvf33;
    logic [15:0] mCnt;
    int          checkCount = 0;
    int          passCount = 0;
    bit          randomReady = 1'b0;

    mac_accumulator #(.ACC_W(40), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .prod_in(prodIn), .in_valid(inValid),
        .in_last(inLast), .in_ready(inReady), .out_valid(outValid),
        .out_ready(outReady), .acc_out(accOut), .cnt_out(cntOut),
        .ovf_out(ovfOut)
    );

    mac_accumulator #(.ACC_W(33), .CNT_W(16)) dut33 (
        .clk(clk), .rst(rst), .prod_in(prodIn), .in_valid(inValid),
        .in_last(inLast), .in_ready(inReady33), .out_valid(outValid33),
        .out_ready(outReady), .acc_out(accOut33), .cnt_out(cntOut33),
        .ovf_out(ovfOut33)
    );

    always #5 clk = ~clk;

    // Single comparison point. Every check is counted here.
    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    // Wraps an exact integer into a signed value that is w bits wide.
    function automatic longint wrapTo(input longint v, input int w);
        longint m;
        m = v & ((longint'(1) << w) - 1);
        if (m >= (longint'(1) << (w - 1))) m = m - (longint'(1) << w);
        return m;
    endfunction

    function automatic logic overflows(input longint v, input int w);
        return (v > ((longint'(1) << (w - 1)) - 1)) || (v < -(longint'(1) << (w - 1)));
    endfunction

    task automatic modelReset();
        model40 = 0;
        model33 = 0;
        mOvf40  = 1'b0;
        mOvf33  = 1'b0;
        mCnt    = '0;
    endtask

    // Reference model. It adds the beat exactly, flags any result outside
    // the signed range, and then wraps to each width.
    task automatic modelBeat(input logic [31:0] v, input logic last);
        longint  p, t40, t33;
        result_t r;
        p   = longint'($signed(v));
        t40 = model40 + p;
        t33 = model33 + p;
        if (overflows(t40, 40)) mOvf40 = 1'b1;
        if (overflows(t33, 33)) mOvf33 = 1'b1;
        model40 = wrapTo(t40, 40);
        model33 = wrapTo(t33, 33);
        if (mCnt != 16'hFFFF) mCnt = mCnt + 16'd1;
        if (last) begin
            r.acc40 = model40[39:0];
            r.ovf40 = mOvf40;
            r.acc33 = model33[32:0];
            r.ovf33 = mOvf33;
            r.cnt   = mCnt;
            expQ.push_back(r);
            modelReset();
        end
    endtask

    // Presents one beat and returns #1 after the edge that accepts it.
    // in_valid stays high, so the caller can chain beats back to back.
    task automatic applyStimulus(input logic [31:0] v, input logic last);
        int guard;
        prodIn  = v;
        inLast  = last;
        inValid = 1'b1;
        guard   = 0;
        while (!inReady && guard < 1000) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!inReady) begin
            checkOutput("beat accept timeout", 64'd0, 64'd1);
            inValid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        modelBeat(v, last);
        if (last) checkOutput("out_valid one cycle after last", outValid, 1);
    endtask

    // Random consumer stalls, used only during the streaming phase.
    initial begin
        forever begin
            @(posedge clk); #1;
            if (randomReady) outReady = ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor. While a result is shown, it must equal the head of the
    // queue, on every cycle. The entry is retired when the consumer
    // takes it.
    always @(negedge clk) begin : monitor
        result_t e;
        if (!rst && outValid) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected result", 64'd1, 64'd0);
            end else begin
                e = expQ[0];
                checkOutput("acc_out", accOut, e.acc40);
                checkOutput("cnt_out", cntOut, e.cnt);
                checkOutput("ovf_out", ovfOut, e.ovf40);
                checkOutput("out_valid w33", outValid33, 1);
                checkOutput("acc_out w33", accOut33, e.acc33);
                checkOutput("cnt_out w33", cntOut33, e.cnt);
                checkOutput("ovf_out w33", ovfOut33, e.ovf33);
                if (outReady) void'(expQ.pop_front());
            end
        end
    end

    initial begin : mainSeq
        int guard;
        int len;
        modelReset();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        checkOutput("reset in_ready", inReady, 1);
        checkOutput("reset out_valid", outValid, 0);
        checkOutput("reset acc_out", accOut, 0);
        checkOutput("reset cnt_out", cntOut, 0);
        checkOutput("reset ovf_out", ovfOut, 0);

        // 100 + -30 + 5 = 75 over three consecutive beats.
        applyStimulus(32'd100, 1'b0);
        applyStimulus(32'hFFFF_FFE2, 1'b0);
        applyStimulus(32'd5, 1'b1);
        inValid = 1'b0;
        @(posedge clk); #1;
        checkOutput("out_valid cleared after accept", outValid, 0);
        checkOutput("in_ready back after accept", inReady, 1);

        // Most negative product, as a single-beat group.
        applyStimulus(32'h8000_0000, 1'b1);
        inValid = 1'b0;

        // Overflow wraps the 33-bit instance. The next group starts clean.
        applyStimulus(32'h7FFF_FFFF, 1'b0);
        applyStimulus(32'h7FFF_FFFF, 1'b0);
        applyStimulus(32'h7FFF_FFFF, 1'b1);
        applyStimulus(32'd1, 1'b0);
        applyStimulus(32'd1, 1'b1);
        inValid = 1'b0;
        @(posedge clk); #1;

        // Consumer stalls while a producer waits with value 7.
        outReady = 1'b0;
        applyStimulus(32'd20, 1'b1);
        prodIn  = 32'd7;
        inLast  = 1'b0;
        inValid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checkOutput("in_ready low in HOLD", inReady, 0);
            checkOutput("out_valid held in HOLD", outValid, 1);
            if (i < 4) begin
                @(posedge clk); #1;
            end
        end
        outReady = 1'b1;
        @(posedge clk); #1;
        checkOutput("out_valid after release", outValid, 0);
        checkOutput("in_ready after release", inReady, 1);
        applyStimulus(32'd7, 1'b0);
        applyStimulus(32'd3, 1'b1);
        inValid = 1'b0;
        @(posedge clk); #1;

        // Reset aborts a partial group. It also wins over a beat offered
        // on the same edge.
        applyStimulus(32'd3, 1'b0);
        applyStimulus(32'd4, 1'b0);
        prodIn = 32'd50;
        rst    = 1'b1;
        @(posedge clk); #1;
        rst     = 1'b0;
        inValid = 1'b0;
        modelReset();
        checkOutput("in_ready after mid-group reset", inReady, 1);
        applyStimulus(32'd9, 1'b0);
        applyStimulus(32'd1, 1'b1);
        inValid = 1'b0;
        @(posedge clk); #1;

        // Reset while a result is pending drops the result.
        outReady = 1'b0;
        applyStimulus(32'd55, 1'b1);
        inValid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        expQ.delete();
        checkOutput("HOLD reset out_valid", outValid, 0);
        checkOutput("HOLD reset in_ready", inReady, 1);
        checkOutput("HOLD reset acc_out", accOut, 0);
        checkOutput("HOLD reset cnt_out", cntOut, 0);
        checkOutput("HOLD reset acc_out w33", accOut33, 0);
        outReady = 1'b1;

        // Back-to-back groups with random values and random consumer stalls.
        randomReady = 1'b1;
        for (int g = 0; g < 8; g++) begin
            len = 1 + (g % 5);
            for (int b = 0; b < len; b++) begin
                applyStimulus($urandom, (b == len - 1));
            end
        end
        inValid     = 1'b0;
        randomReady = 1'b0;
        outReady    = 1'b1;
        guard       = 0;
        while (expQ.size() > 0 && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        checkOutput("results left undelivered", expQ.size(), 0);
        repeat (3) @(posedge clk);
        #1 checkOutput("idle out_valid", outValid, 0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
